hex_step_counter: RTL and testbench
===================================

Name: hex_step_counter

Overview:
- Upstream source for the team's 7-segment hex decoders.
- Takes a raw active-low pushbutton and debounces it. Each clean press steps a NUM_DIGITS-digit hex counter up or down.
- Presents the count as packed 4-bit nibbles. Each nibble drives one decoder instance (HEX0, HEX1, ...).

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles a changed input must stay stable before it is accepted (10 ms at 50 MHz); must be >= 2.
- NUM_DIGITS, 4, number of hex digits in the counter (1..8).
- REPEAT_DELAY, 25000000, cycles a key must be held before auto-repeat starts (used only with HEX_AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between auto-repeat steps (used only with HEX_AUTO_REPEAT_EN).

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_n  input  1  raw pushbutton, asynchronous to clk, 0 = pressed.
- up_dn  input  1  step direction: 1 = increment, 0 = decrement; sampled on the step edge.
- clr  input  1  synchronous clear of the count.
- count  output  NUM_DIGITS*4  packed digits; digit i = count[4i+3:4i], digit 0 is least significant.
- step_pulse  output  1  one-cycle strobe, high in the cycle after each accepted step.

Behaviour:
- Reset (async assert, sync release): sync flops = 1, key_stable = 1, debounce counter = 0, count = 0, step_pulse = 0.
- Synchroniser: key_n passes through 2 flops to give key_sync. No other logic samples key_n directly.
- Debounce:
  - If key_sync == key_stable, the debounce counter clears to 0.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with key_sync still different, key_stable <= key_sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes key_stable.
- Press event: key_stable changes from 1 to 0. Release (0 to 1) generates nothing.
- Step, on the edge where the press event is registered:
  - count <= count+1 if up_dn = 1, else count-1.
  - Arithmetic is modulo 2^(4*NUM_DIGITS). All-F +1 wraps to 0; 0 -1 wraps to all-F. Carries ripple across digits as a plain binary counter.
  - step_pulse is high for exactly that following cycle.
- Latency: key_n held low continuously gives its count change 2 + DEBOUNCE_CYCLES clk edges after the first low sample.
- clr:
  - Clears count to 0 on the next edge.
  - Has priority over a simultaneous step; that step is discarded and step_pulse stays 0.
  - Does not affect the debounce state.
- Reset mid-debounce: all state returns to reset values. A key still held after release of reset is a new press and is accepted after the full debounce interval.
- count is registered and glitch-free, so it is safe to feed the combinational decoders directly.

Optional Feature:
- Macro: HEX_AUTO_REPEAT_EN.
- Defined:
  - A repeat timer starts at the press event.
  - While key_stable stays 0, an extra step occurs REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - Each repeat step obeys the same up_dn, clr priority and step_pulse rules.
  - Release (key_stable = 1) or clr clears the timer.
- Not defined: no repeat timer logic is synthesised; exactly one step per press. REPEAT_* parameters are ignored.

Decomposition:
- Shared package hex_disp_pkg:
  - DIGIT_W = 4.
  - Default DEBOUNCE_CYCLES.
  - Function digit_sel(count, i) returning nibble i.
- Sub-module key_debouncer (synchroniser + debounce counter + press-edge detect). Parameter DEBOUNCE_CYCLES; outputs key_stable and press. It is reused for other board keys.
- The counter and optional repeat logic stay in hex_step_counter.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and NUM_DIGITS=4 unless stated.
1. Reset → count = 16'h0000, step_pulse = 0. Then press key_n low for 10 cycles with up_dn = 1 → count = 16'h0001 exactly 6 edges after the first low sample; single step_pulse; release gives no change.
2. key_n bounces 0/1 with pulses of 1–3 cycles for 40 cycles, then holds 0 → exactly one increment; no step during the bounce window.
3. count = 16'hFFFF, up_dn = 1, one press → 16'h0000. Then up_dn = 0, one press → 16'hFFFF. Also count = 16'h00FF +1 → 16'h0100.
4. clr asserted on the same edge as a step → count = 0, step_pulse = 0. Next press → 16'h0001.
5. Assert rst_n mid-debounce (key low for 2 cycles); hold key low through reset release → count stays 0 during reset, then increments once 6 edges after release.
6. With HEX_AUTO_REPEAT_EN, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, key held 50 cycles after acceptance → steps at acceptance, +20, +28, +36, +44 (count = 5). Without the macro → count = 1.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display path: digit width, default debounce
// interval and a nibble selector for the packed digit bus.
package hex_disp_pkg;

  localparam int unsigned DIGIT_W             = 4;
  localparam int unsigned MAX_DIGITS          = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

  // Return nibble i of a packed count (digit 0 is least significant).
  function automatic logic [DIGIT_W-1:0] digit_sel(
    input logic [DIGIT_W*MAX_DIGITS-1:0] count,
    input int unsigned                   i
  );
    logic [DIGIT_W*MAX_DIGITS-1:0] shifted;
    shifted   = count >> (DIGIT_W * i);
    digit_sel = shifted[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser, stability counter and press-edge
// detector for a raw active-low pushbutton.
//   clk, rst_n  : clock, async active-low reset
//   key_n       : raw key, asynchronous to clk, 0 = pressed
//   key_stable  : debounced key level (1 = released)
//   press       : one-cycle pulse in the cycle after key_stable falls 1 -> 0
module key_debouncer
  import hex_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_stable_q, key_stable_d;
  logic          press_q, press_d;

  // Synchroniser feed, stability counting and edge detection.
  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    cnt_d        = '0;
    key_stable_d = key_stable_q;
    press_d      = 1'b0;
    if (sync2_q != key_stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        key_stable_d = sync2_q;
        press_d      = ~sync2_q;  // only the falling edge is a press
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      key_stable_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      key_stable_q <= key_stable_d;
      press_q      <= press_d;
    end
  end

  assign key_stable = key_stable_q;
  assign press      = press_q;

endmodule

// File: rtl/hex_step_counter.sv
// hex_step_counter: debounced pushbutton stepping a NUM_DIGITS-digit hex
// up/down counter that feeds the 7-segment decoders.
//   clk, rst_n  : clock, async active-low reset
//   key_n       : raw pushbutton, 0 = pressed
//   up_dn       : 1 = increment, 0 = decrement
//   clr         : synchronous clear of the count (wins over a step)
//   count       : packed digits, digit i = count[4i+3:4i]
//   step_pulse  : high for the cycle after each accepted step
// Build option: define HEX_AUTO_REPEAT_EN to add hold-to-repeat stepping
// (first repeat REPEAT_DELAY cycles after the press, then every
// REPEAT_PERIOD cycles while the key stays down).
module hex_step_counter
  import hex_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_n,
  input  logic                          up_dn,
  input  logic                          clr,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic                          step_pulse
);

  localparam int unsigned CNT_W = NUM_DIGITS * DIGIT_W;

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..8");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic key_stable;
  logic press;
  logic step_req_c;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_stable(key_stable),
    .press     (press)
  );

`ifdef HEX_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic          rep_active_q, rep_active_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire_c;

  // Down-counting repeat timer: armed by a press, fires at zero, reloads
  // with the period; release or clr disarms it.
  always_comb begin
    rep_active_d = rep_active_q;
    rep_cnt_d    = rep_cnt_q;
    rep_fire_c   = 1'b0;
    if (clr || key_stable) begin
      rep_active_d = 1'b0;
      rep_cnt_d    = '0;
    end else if (press) begin
      rep_active_d = 1'b1;
      rep_cnt_d    = RW'(REPEAT_DELAY - 1);
    end else if (rep_active_q) begin
      if (rep_cnt_q == '0) begin
        rep_fire_c = 1'b1;
        rep_cnt_d  = RW'(REPEAT_PERIOD - 1);
      end else begin
        rep_cnt_d = rep_cnt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_active_q <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      rep_active_q <= rep_active_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  assign step_req_c = press | rep_fire_c;
`else
  // A press always coincides with key_stable low; the qualifier keeps the
  // step tied to a held key in both builds.
  assign step_req_c = press & ~key_stable;
`endif

  logic [CNT_W-1:0] count_q, count_d;
  logic             step_pulse_q, step_pulse_d;

  // Count update: clr first, then a step in the sampled direction.
  always_comb begin
    count_d      = count_q;
    step_pulse_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (step_req_c) begin
      count_d      = up_dn ? (count_q + CNT_W'(1)) : (count_q - CNT_W'(1));
      step_pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign count      = count_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_hex_step_counter.sv
// Directed self-checking bench for hex_step_counter with a short debounce
// interval and short repeat timings.
module tb_hex_step_counter;
  import hex_disp_pkg::*;

  localparam int unsigned DC = 4;
  localparam int unsigned ND = 4;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic        up_dn;
  logic        clr;
  logic [15:0] count;
  logic        step_pulse;

  int n_checks;
  int n_errors;
  int n_pulses;

  hex_step_counter #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_DIGITS     (ND),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .up_dn     (up_dn),
    .clr       (clr),
    .count     (count),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes, sampled mid-cycle.
  always @(negedge clk) if (step_pulse) n_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press long enough to step once, then a release long enough for
  // key_stable to settle back high before the next press.
  task automatic press_key();
    key_n = 1'b0;
    tick(8);
    key_n = 1'b1;
    tick(8);
  endtask

  int bounce [20] = '{3,1,2,3,1,2,3,3,2,1,3,2,1,3,2,3,1,2,3,1};
  int p0;
  logic [31:0] exp_rep;

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pulses = 0;
    rst_n = 1'b0;
    key_n = 1'b1;
    up_dn = 1'b1;
    clr   = 1'b0;
    tick(3);
    check("reset_count", 32'(count), 32'h0000);
    check("reset_pulse", 32'(step_pulse), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Latency: first low sample at e1, count changes at e7.
    key_n = 1'b0;
    tick(6);
    check("latency_before", 32'(count), 32'h0000);
    tick(1);
    check("latency_step", 32'(count), 32'h0001);
    check("latency_pulse", 32'(step_pulse), 32'h1);
    tick(1);
    check("pulse_one_cycle", 32'(step_pulse), 32'h0);
    tick(2);
    key_n = 1'b1;
    tick(12);
    check("release_no_step", 32'(count), 32'h0001);
    check("pulse_total_1", 32'(n_pulses), 32'd1);

    // Bounce window shorter than the debounce interval, then a hold.
    for (int i = 0; i < 20; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(bounce[i]);
    end
    check("bounce_no_step", 32'(count), 32'h0001);
    check("bounce_no_pulse", 32'(n_pulses), 32'd1);
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
    check("bounce_then_hold", 32'(count), 32'h0002);

    // Wrap-around in both directions.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_count", 32'(count), 32'h0000);
    up_dn = 1'b0;
    press_key();
    check("dec_wrap", 32'(count), 32'hFFFF);
    up_dn = 1'b1;
    press_key();
    check("inc_wrap", 32'(count), 32'h0000);
    up_dn = 1'b0;
    press_key();
    check("dec_wrap_again", 32'(count), 32'hFFFF);
    up_dn = 1'b1;
    press_key();
    for (int i = 0; i < 255; i++) press_key();
    check("count_00ff", 32'(count), 32'h00FF);
    press_key();
    check("carry_0100", 32'(count), 32'h0100);
    check("digit2_sel", 32'(digit_sel(32'(count), 2)), 32'h1);
    check("digit0_sel", 32'(digit_sel(32'(count), 0)), 32'h0);

    // clr on the same edge as a step.
    p0 = n_pulses;
    key_n = 1'b0;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_vs_step_count", 32'(count), 32'h0000);
    check("clr_vs_step_pulse", 32'(step_pulse), 32'h0);
    tick(2);
    key_n = 1'b1;
    tick(10);
    check("clr_vs_step_no_pulse", 32'(n_pulses - p0), 32'd0);
    press_key();
    check("after_clr_press", 32'(count), 32'h0001);

    // Reset in mid-debounce with the key held through release.
    key_n = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("mid_reset_count", 32'(count), 32'h0000);
    tick(3);
    check("in_reset_count", 32'(count), 32'h0000);
    rst_n = 1'b1;
    tick(6);
    check("post_reset_before", 32'(count), 32'h0000);
    tick(1);
    check("post_reset_step", 32'(count), 32'h0001);
    key_n = 1'b1;
    tick(10);

    // Long hold: repeat steps at +20, +28, +36, +44 when enabled.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    key_n = 1'b0;
    tick(7);
    check("hold_first_step", 32'(count), 32'h0001);
    tick(40);
    key_n = 1'b1;
    tick(20);
`ifdef HEX_AUTO_REPEAT_EN
    exp_rep = 32'h0005;
`else
    exp_rep = 32'h0001;
`endif
    check("hold_repeat", 32'(count), exp_rep);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
